// File: rtl/sbs_pkg.sv
// sbs_pkg: shared FSM state type and index-width helper for set_bit_scheduler.
package sbs_pkg;

    typedef enum logic {IDLE, EMIT} sbs_state_t;

    function automatic int idx_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/set_bit_scheduler_ffs.sv
// ffs_encoder: find-first-set over vec_i, searching upward from start_i and wrapping to bit 0.
module ffs_encoder
    import sbs_pkg::*;
#(
    parameter  int N  = 8,
    localparam int IW = idx_w(N)
) (
    input  logic [N-1:0]  vec_i,
    input  logic [IW-1:0] start_i,
    output logic          found_o,
    output logic [IW-1:0] idx_o
);

    logic [IW-1:0] lo;
    logic [IW-1:0] hi;
    logic          hit;

    // Descending scan leaves the lowest match overall in lo and the lowest at/above start_i in hi.
    always_comb begin
        found_o = |vec_i;
        lo      = '0;
        hi      = '0;
        hit     = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                lo = IW'(i);
                if (i >= int'(start_i)) begin
                    hi  = IW'(i);
                    hit = 1'b1;
                end
            end
        end
        idx_o = hit ? hi : lo;
    end

endmodule

// File: rtl/set_bit_scheduler.sv
// set_bit_scheduler: issues the index of every set bit of an accepted vector, one per beat.
// Define SBS_ROTATE_EN to start each search at a persistent rotate pointer instead of bit 0.
module set_bit_scheduler
    import sbs_pkg::*;
#(
    parameter  int N  = 8,
    localparam int IW = idx_w(N)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_vec,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [IW-1:0] out_index,
    output logic          out_last,
    output logic          done
);

    sbs_state_t    state_q, state_d;
    logic [N-1:0]  vec_q, vec_d;
    logic          done_q, done_d;
    logic [IW-1:0] start;
    logic [IW-1:0] idx;
    logic          found;
    logic          beat;
    logic          last;
    logic          accept;

`ifdef SBS_ROTATE_EN
    logic [IW-1:0] ptr_q, ptr_d;
    assign start = ptr_q;
`else
    assign start = '0;
`endif

    ffs_encoder #(.N(N)) u_ffs (
        .vec_i   (vec_q),
        .start_i (start),
        .found_o (found),
        .idx_o   (idx)
    );

    assign done = done_q;

    always_comb begin
        out_valid = (state_q == EMIT) & found;
        last      = (vec_q & (vec_q - N'(1))) == '0;
        out_last  = out_valid & last;
        out_index = out_valid ? idx : '0;
        beat      = out_valid & out_ready;
        in_ready  = ~flush & ((state_q == IDLE) | (beat & last));
        accept    = in_valid & in_ready;
        state_d   = state_q;
        vec_d     = vec_q;
        done_d    = 1'b0;
`ifdef SBS_ROTATE_EN
        ptr_d     = ptr_q;
`endif
        if (beat) begin
            vec_d = vec_q & ~(N'(1) << idx);
`ifdef SBS_ROTATE_EN
            ptr_d = (idx == IW'(N - 1)) ? '0 : idx + IW'(1);
`endif
            if (last) begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
        end
        // A zero vector completes without beats; a nonzero one loads over the drained work register.
        if (accept) begin
            if (in_vec == '0) begin
                done_d  = 1'b1;
                state_d = IDLE;
            end else begin
                vec_d   = in_vec;
                state_d = EMIT;
            end
        end
        if (flush) begin
            state_d = IDLE;
            vec_d   = '0;
            done_d  = 1'b0;
`ifdef SBS_ROTATE_EN
            ptr_d   = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            vec_q   <= '0;
            done_q  <= 1'b0;
`ifdef SBS_ROTATE_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            done_q  <= done_d;
`ifdef SBS_ROTATE_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

endmodule
